// File: rtl/timers_pkg.sv
// Shared timer definitions: capture FSM encoding, strobe divide selects and
// the default count width.
package timers_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FULL  = 2'd2,
      OVR   = 2'd3
   } capt_state_t;

   localparam logic [1:0] PSEL_DIV1 = 2'd0;
   localparam logic [1:0] PSEL_DIV2 = 2'd1;
   localparam logic [1:0] PSEL_DIV4 = 2'd2;
   localparam logic [1:0] PSEL_DIV8 = 2'd3;

   // Terminal divider value for a given select: 2^psel - 1.
   function automatic logic [2:0] strobe_last(input logic [1:0] psel);
      logic [2:0] last;
      case (psel)
         PSEL_DIV1: last = 3'd0;
         PSEL_DIV2: last = 3'd1;
         PSEL_DIV4: last = 3'd3;
         default:   last = 3'd7;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/timers_timer2_capt_ctrl_if.sv
// Strobe-control bundle between the capture controller and the sample-strobe
// divider feeding the pulse filter.
interface timers_timer2_capt_ctrl_if;
   logic       capen;
   logic [1:0] psel;
   logic       pdf_enable;

   modport master (output capen, output psel, input pdf_enable);
   modport slave  (input capen, input psel, output pdf_enable);
endinterface

// File: rtl/timers_timer2_strobe_gen.sv
// Sample-strobe divider: 3-bit counter wrapping every 2^psel clocks, with a
// registered one-cycle strobe at the terminal count.
module timers_timer2_strobe_gen
   import timers_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   timers_timer2_capt_ctrl_if.slave      sif
);

   logic [2:0] div_q, div_d;
   logic [1:0] psel_q;
   logic       en_q, en_d;
   logic [2:0] last;

   always_comb begin
      last  = strobe_last(sif.psel);
      div_d = div_q;
      en_d  = 1'b0;
      // A select change restarts the period so the new rate starts cleanly.
      if (!sif.capen || (sif.psel != psel_q)) begin
         div_d = 3'd0;
      end else if (div_q == last) begin
         div_d = 3'd0;
      end else begin
         div_d = div_q + 3'd1;
      end
      en_d = sif.capen && (div_d == last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= 3'd0;
         psel_q <= PSEL_DIV1;
         en_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         psel_q <= sif.psel;
         en_q   <= en_d;
      end
   end

   assign sif.pdf_enable = en_q;

endmodule

// File: rtl/timers_timer2_capt_ctrl.sv
// Timer-2 capture controller: capture FSM, capture register and strobe divider.
// Define TIMERS_TIMER2_CAPT_OVERRUN_EN to overwrite on an unread capture and flag overrun.
module timers_timer2_capt_ctrl
   import timers_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic             timers_timer2_clock_i_b,
   input  logic             timers_timer2_reset_i,
   input  logic             timers_sfr_tcon2_capen_i,
   input  logic [1:0]       timers_sfr_tcon2_psel_i,
   input  logic [CNT_W-1:0] timers_timer2_count_i,
   input  logic             timers_timer2_pdfoutput_i,
   input  logic             timers_sfr_capt_rd_i,
   output logic             timers_timer2_pdf_enable_o,
   output logic [CNT_W-1:0] timers_timer2_capt_o,
   output logic             timers_timer2_capt_irq_o,
   output logic             timers_timer2_capt_ovf_o
);

   timers_timer2_capt_ctrl_if strobe_if ();

   assign strobe_if.capen            = timers_sfr_tcon2_capen_i;
   assign strobe_if.psel             = timers_sfr_tcon2_psel_i;
   assign timers_timer2_pdf_enable_o = strobe_if.pdf_enable;

   timers_timer2_strobe_gen u_strobe_gen (
      .clk   (timers_timer2_clock_i_b),
      .rst_n (timers_timer2_reset_i),
      .sif   (strobe_if.slave)
   );

   capt_state_t      state_q, state_d;
   logic [CNT_W-1:0] capt_q, capt_d;
   logic             irq_q, irq_d;
   logic             ovf_q, ovf_d;
   logic             evt, rd;

   assign evt = timers_timer2_pdfoutput_i;
   assign rd  = timers_sfr_capt_rd_i;

   always_comb begin
      state_d = state_q;
      capt_d  = capt_q;
      irq_d   = irq_q;
      ovf_d   = ovf_q;
      if (!timers_sfr_tcon2_capen_i) begin
         state_d = IDLE;
         irq_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (evt) begin
                  capt_d  = timers_timer2_count_i;
                  irq_d   = 1'b1;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (rd && evt) begin
                  capt_d = timers_timer2_count_i;
               end else if (rd) begin
                  irq_d   = 1'b0;
                  state_d = ARMED;
               end else if (evt) begin
`ifdef TIMERS_TIMER2_CAPT_OVERRUN_EN
                  capt_d  = timers_timer2_count_i;
                  ovf_d   = 1'b1;
                  state_d = OVR;
`else
                  capt_d  = capt_q;
`endif
               end
            end
            OVR: begin
               // A read acknowledges both flags; a coincident event is dropped.
               if (rd) begin
                  irq_d   = 1'b0;
                  ovf_d   = 1'b0;
                  state_d = ARMED;
               end else if (evt) begin
                  capt_d = timers_timer2_count_i;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge timers_timer2_clock_i_b or negedge timers_timer2_reset_i) begin
      if (!timers_timer2_reset_i) begin
         state_q <= IDLE;
         capt_q  <= '0;
         irq_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         capt_q  <= capt_d;
         irq_q   <= irq_d;
         ovf_q   <= ovf_d;
      end
   end

   assign timers_timer2_capt_o     = capt_q;
   assign timers_timer2_capt_irq_o = irq_q;
`ifdef TIMERS_TIMER2_CAPT_OVERRUN_EN
   assign timers_timer2_capt_ovf_o = ovf_q;
`else
   assign timers_timer2_capt_ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_timers_timer2_capt_ctrl.sv
// Bench for timers_timer2_capt_ctrl: directed scenarios plus random traffic
// checked every cycle against a flag-based reference model.
module tb_timers_timer2_capt_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] count;
   logic         evt, rd;
   logic [W-1:0] capt;
   logic         irq, ovf;

   always #5 clk = ~clk;

   timers_timer2_capt_ctrl_if tb_if ();

   timers_timer2_capt_ctrl #(.CNT_W(W)) dut (
      .timers_timer2_clock_i_b    (clk),
      .timers_timer2_reset_i      (rst_n),
      .timers_sfr_tcon2_capen_i   (tb_if.capen),
      .timers_sfr_tcon2_psel_i    (tb_if.psel),
      .timers_timer2_count_i      (count),
      .timers_timer2_pdfoutput_i  (evt),
      .timers_sfr_capt_rd_i       (rd),
      .timers_timer2_pdf_enable_o (tb_if.pdf_enable),
      .timers_timer2_capt_o       (capt),
      .timers_timer2_capt_irq_o   (irq),
      .timers_timer2_capt_ovf_o   (ovf)
   );

   int n_total = 0;
   int n_bad   = 0;
   bit verbose = 1'b0;

   // Reference model: enabled/pending/overrun flags, last capture, strobe phase.
   bit           m_active, m_irq, m_ovf, m_en;
   logic [W-1:0] m_capt;
   int           m_phase;
   logic [1:0]   m_psel_prev;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_irq = 0; m_ovf = 0; m_en = 0;
      m_capt = '0; m_phase = 0; m_psel_prev = 2'd0;
   endtask

   task automatic model_step(input bit c, input bit [1:0] p, input logic [W-1:0] n,
                             input bit e, input bit r);
      int period;
      period = 1 << p;
      if (!c || p != m_psel_prev) m_phase = 0;
      else m_phase = (m_phase + 1) % period;
      m_en = c && (m_phase == period - 1);
      m_psel_prev = p;

      if (!c) begin
         m_active = 0; m_irq = 0; m_ovf = 0;
      end else if (!m_active) begin
         m_active = 1;
      end else if (!m_irq) begin
         if (e) begin m_capt = n; m_irq = 1; end
      end else if (!m_ovf) begin
         if (r) begin
            if (e) m_capt = n;
            else m_irq = 0;
         end else if (e) begin
`ifdef TIMERS_TIMER2_CAPT_OVERRUN_EN
            m_capt = n; m_ovf = 1;
`endif
         end
      end else begin
         if (r) begin m_irq = 0; m_ovf = 0; end
         else if (e) m_capt = n;
      end
   endtask

   task automatic check_outputs();
      chk_val("capt",   capt,             m_capt);
      chk_val("irq",    irq,              m_irq);
      chk_val("ovf",    ovf,              m_ovf);
      chk_val("pdf_en", tb_if.pdf_enable, m_en);
   endtask

   // Called at a falling edge: drive, let one rising edge pass, check.
   task automatic cyc(input bit c, input bit [1:0] p, input logic [W-1:0] n,
                      input bit e, input bit r);
      tb_if.capen = c; tb_if.psel = p; count = n; evt = e; rd = r;
      @(posedge clk);
      model_step(c, p, n, e, r);
      @(negedge clk);
      check_outputs();
      if (verbose)
         $display("txn capen=%0d psel=%0d cnt=%h evt=%0d rd=%0d -> capt=%h irq=%0d ovf=%0d en=%0d",
                  c, p, n, e, r, capt, irq, ovf, tb_if.pdf_enable);
   endtask

   initial begin
      bit [1:0] cur_p;
      rst_n = 1'b0; tb_if.capen = 1'b0; tb_if.psel = 2'd0;
      count = '0; evt = 1'b0; rd = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      verbose = 1'b1;

      // Strobe: psel=2 pulses every 4th clock, psel=0 constant, capen=0 kills it.
      for (int i = 0; i < 10; i++) cyc(1, 2'd2, '0, 0, 0);
      for (int i = 0; i < 4; i++)  cyc(1, 2'd0, '0, 0, 0);
      cyc(0, 2'd0, '0, 0, 0);
      chk_val("en_off", tb_if.pdf_enable, 1'b0);

      // Basic capture and acknowledge.
      cyc(1, 2'd0, '0, 1, 0);
      chk_val("idle_evt_ignored", irq, 1'b0);
      cyc(1, 2'd0, 16'h1234, 1, 0);
      chk_val("capt_1234", capt, 16'h1234);
      chk_val("irq_set", irq, 1'b1);
      cyc(1, 2'd0, '0, 0, 1);
      chk_val("irq_clr", irq, 1'b0);

      // Read and event together while full.
      cyc(1, 2'd0, 16'h0010, 1, 0);
      cyc(1, 2'd0, 16'h0020, 1, 1);
      chk_val("rdevt_capt", capt, 16'h0020);
      chk_val("rdevt_irq", irq, 1'b1);
      chk_val("rdevt_ovf", ovf, 1'b0);

      // Unread capture followed by another event.
      cyc(1, 2'd0, '0, 0, 1);
      cyc(1, 2'd0, 16'h0010, 1, 0);
      cyc(1, 2'd0, 16'h0030, 1, 0);
`ifdef TIMERS_TIMER2_CAPT_OVERRUN_EN
      chk_val("ovr_capt", capt, 16'h0030);
      chk_val("ovr_flag", ovf, 1'b1);
`else
      chk_val("ovr_capt", capt, 16'h0010);
      chk_val("ovr_flag", ovf, 1'b0);
`endif

      // Asynchronous reset while full with irq pending.
      cyc(1, 2'd0, '0, 0, 1);
      cyc(1, 2'd0, 16'h0055, 1, 0);
      chk_val("pre_rst_irq", irq, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_val("rst_capt", capt, 16'h0000);
      chk_val("rst_irq", irq, 1'b0);
      chk_val("rst_ovf", ovf, 1'b0);
      chk_val("rst_en", tb_if.pdf_enable, 1'b0);
      model_reset();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      cyc(1, 2'd0, 16'h0066, 1, 0);
      chk_val("post_rst_idle", irq, 1'b0);
      cyc(1, 2'd0, 16'h0077, 1, 0);
      chk_val("post_rst_capt", capt, 16'h0077);
      chk_val("post_rst_irq", irq, 1'b1);

      // Random traffic.
      verbose = 1'b0;
      cur_p = 2'd0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) cur_p = 2'($urandom_range(0, 3));
         cyc(($urandom_range(0, 15) != 0), cur_p, W'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/timers_timer2_capt_ctrl.md
TIMERS_TIMER2_CAPT_CTRL -- requirements
Module: timers_timer2_capt_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of timer-2 count and capture register.
REQ-002 Port: timers_timer2_clock_i_b  input  1  block clock; all state is updated on its rising edge.
REQ-003 Port: timers_timer2_reset_i  input  1  reset, asynchronous, active-low.
REQ-004 Port: timers_sfr_tcon2_capen_i  input  1  capture enable from the SFR.
REQ-005 Port: timers_sfr_tcon2_psel_i  input  2  sample-strobe divide select (period 1/2/4/8 clocks).
REQ-006 Port: timers_timer2_count_i  input  CNT_W  running timer-2 count.
REQ-007 Port: timers_timer2_pdfoutput_i  input  1  one-cycle filtered edge event from the pulse filter.
REQ-008 Port: timers_sfr_capt_rd_i  input  1  one-cycle CPU read strobe of the capture register.
REQ-009 Port: timers_timer2_pdf_enable_o  output  1  sample strobe to the pulse filter.
REQ-010 Port: timers_timer2_capt_o  output  CNT_W  captured count.
REQ-011 Port: timers_timer2_capt_irq_o  output  1  capture-pending interrupt flag.
REQ-012 Port: timers_timer2_capt_ovf_o  output  1  capture overrun flag.

Function
REQ-013 The strobe divider SHALL be a 3-bit counter with a period of 2^psel clocks; pdf_enable_o SHALL be high for one cycle when the counter equals 2^psel-1.
REQ-014 With psel=0, pdf_enable_o SHALL be constantly high while capen=1.
REQ-015 While capen=0, the divider SHALL be held at 0 and pdf_enable_o SHALL be low.
REQ-016 A change of psel SHALL clear the divider in the next cycle.
REQ-017 The FSM SHALL have four states: IDLE, ARMED, FULL, OVR.
REQ-018 IDLE->ARMED when capen=1; from any state, capen=0 SHALL force IDLE in the next cycle, clear irq and ovf, and leave capt_o holding its value.
REQ-019 ARMED with an event: capt_o<=count_i sampled in the event cycle (registered, 1-cycle latency), irq<=1, next state FULL.
REQ-020 FULL with rd and no event: irq<=0, next state ARMED.
REQ-021 FULL with rd and event in the same cycle: new capture, irq stays 1, state stays FULL, no overrun.
REQ-022 FULL with event and no rd: behaviour is defined in REQ-027/REQ-028.
REQ-023 OVR with rd: irq<=0, ovf<=0, next state ARMED.
REQ-024 OVR with event and no rd: capt_o is overwritten; the state stays OVR.
REQ-025 Events in IDLE SHALL be ignored; an rd in IDLE or ARMED SHALL have no effect.
REQ-026 The event input is trusted to be single-cycle; a multi-cycle high level SHALL capture once per high cycle under the rules above.

Configuration
REQ-027 With macro TIMERS_TIMER2_CAPT_OVERRUN_EN defined: FULL with event and no rd SHALL overwrite capt_o, set ovf<=1, and go to OVR.
REQ-028 Without TIMERS_TIMER2_CAPT_OVERRUN_EN: the event SHALL be dropped and capt_o held; ovf_o SHALL be tied to 0 and the OVR state SHALL be unreachable.

Reset
REQ-029 Asserting reset (low) SHALL immediately set the state to IDLE and the divider to 0, and set pdf_enable_o=0, capt_o=0, irq=0 and ovf=0, regardless of clock.
REQ-030 Reset release SHALL take effect synchronously on the first rising clock edge after deassertion; the first capture is possible no earlier than 2 cycles after release.

Structure
REQ-031 A shared package timers_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, ARMED=1, FULL=2, OVR=3), the psel decode constants and the CNT_W default.
REQ-032 The divider SHALL be a sub-module, timers_timer2_strobe_gen, instantiated once; the FSM and capture register SHALL reside in the top module.

Verification
REQ-033 psel=2, capen=1: pdf_enable_o SHALL pulse every 4th clock; with psel=0 it SHALL stay high; capen=0 SHALL force it low the next cycle.
REQ-034 ARMED, count=16'h1234, event pulse: capt_o=16'h1234 and irq=1 one cycle later; rd then clears irq and the FSM returns to ARMED.
REQ-035 FULL holding 16'h0010, rd and event (count 16'h0020) in the same cycle: capt_o=16'h0020, irq=1, ovf=0.
REQ-036 FULL holding 16'h0010, event at 16'h0030, no rd: with the macro, capt_o=16'h0030 and ovf=1; without it, capt_o=16'h0010 and ovf=0.
REQ-037 Assert reset mid-FULL with irq=1: all outputs SHALL be 0 asynchronously before the next clock edge; after release with capen=1, the next event SHALL capture normally.
